// File: rtl/game_ctrl.sv
// game_ctrl: control FSM for the minesweeper datapath.
// It screens player guesses for range and repeats. Each valid guess runs through
// the datapath start/load/decode/alu handshake, and the FSM then declares win,
// lose or fault. Every output is registered.
//
// Ports
//   i_clka         clock, all logic on posedge
//   i_restart      synchronous active-high reset
//   i_new_game     begin mine placement (IDLE/WIN/LOSE only)
//   i_guess_valid  i_guess is valid this cycle
//   i_guess        cell index of player guess
//   i_place_done, i_decode_done, i_alu_done   datapath done levels
//   i_gameover     last decoded cell held a mine
//   i_mines        mine map
//   i_cleared      cleared-cell map
//   o_start, o_load, o_decode, o_alu          datapath commands (one-hot or zero)
//   o_data         accepted guess, held from LOAD through CHECK
//   o_ready        high in READY only
//   o_reject       one-cycle pulse for an out-of-range or repeated guess
//   o_win, o_lose, o_fault                   terminal status levels
//   o_moves        accepted-guess count, saturating at 31
//
// state  | meaning
// IDLE   | after reset, waiting for new_game
// PLACE  | start held until place_done
// READY  | accepting guesses
// LOAD   | one-cycle load of the guess
// DECODE | decode held until decode_done
// ALU    | alu held until alu_done
// CHECK  | one cycle to evaluate the gameover/board outcome
// WIN    | board complete
// LOSE   | mine hit
// FAULT  | watchdog expired; only restart leaves
module game_ctrl #(
  parameter int CELLS   = 25,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clka,
  input  logic             i_restart,
  input  logic             i_new_game,
  input  logic             i_guess_valid,
  input  logic [4:0]       i_guess,
  input  logic             i_place_done,
  input  logic             i_decode_done,
  input  logic             i_alu_done,
  input  logic             i_gameover,
  input  logic [CELLS-1:0] i_mines,
  input  logic [CELLS-1:0] i_cleared,
  output logic             o_start,
  output logic             o_load,
  output logic             o_decode,
  output logic             o_alu,
  output logic [4:0]       o_data,
  output logic             o_ready,
  output logic             o_reject,
  output logic             o_win,
  output logic             o_lose,
  output logic             o_fault,
  output logic [4:0]       o_moves
);

  typedef enum logic [3:0] {
    IDLE, PLACE, READY, LOAD, DECODE, ALU, CHECK, WIN, LOSE, FAULT
  } state_t;

  localparam logic [5:0] CELLS_LIM = 6'(CELLS);
  // The last waiting cycle is the one in which the counter holds TIMEOUT-1.
  // A state therefore waits TIMEOUT cycles in total.
  localparam logic [3:0] WD_LAST   = 4'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wd;
  logic [3:0]  w_wd_nxt;
  logic        w_accept;
  logic        w_reject;
  logic        w_bad;
  logic [31:0] w_cleared_ext;
  logic        w_new_ok;

  logic        r_start, r_load, r_decode, r_alu;
  logic        r_ready, r_reject, r_win, r_lose, r_fault;
  logic [4:0]  r_data, r_moves;

  always_comb begin
    // Zero-extend the cleared map so that any 5-bit guess indexes safely.
    w_cleared_ext = 32'(i_cleared);
    w_bad         = ({1'b0, i_guess} >= CELLS_LIM) || w_cleared_ext[i_guess];
    w_new_ok      = i_new_game &&
                    (r_state == IDLE || r_state == WIN || r_state == LOSE);
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    case (r_state)
      IDLE:    if (i_new_game) w_state_nxt = PLACE;
      PLACE:   if (i_place_done) w_state_nxt = READY;
               else if (r_wd == WD_LAST) w_state_nxt = FAULT;
      READY:   if (i_guess_valid) begin
                 if (w_bad) begin
                   w_reject = 1'b1;
                 end else begin
                   w_accept    = 1'b1;
                   w_state_nxt = LOAD;
                 end
               end
      LOAD:    w_state_nxt = DECODE;
      DECODE:  if (i_decode_done) w_state_nxt = ALU;
               else if (r_wd == WD_LAST) w_state_nxt = FAULT;
      ALU:     if (i_alu_done) w_state_nxt = CHECK;
               else if (r_wd == WD_LAST) w_state_nxt = FAULT;
      CHECK:   if (i_gameover) w_state_nxt = LOSE;
               else if (&(i_cleared | i_mines)) w_state_nxt = WIN;
               else w_state_nxt = READY;
      WIN,
      LOSE:    if (i_new_game) w_state_nxt = PLACE;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase

    // The watchdog restarts on every state change and counts only in waiting states.
    if (w_state_nxt != r_state) begin
      w_wd_nxt = 4'd0;
    end else if (r_state == PLACE || r_state == DECODE || r_state == ALU) begin
      w_wd_nxt = r_wd + 4'd1;
    end else begin
      w_wd_nxt = 4'd0;
    end
  end

  always_ff @(posedge i_clka) begin
    if (i_restart) begin
      r_state  <= IDLE;
      r_wd     <= 4'd0;
      r_start  <= 1'b0;
      r_load   <= 1'b0;
      r_decode <= 1'b0;
      r_alu    <= 1'b0;
      r_data   <= 5'd0;
      r_ready  <= 1'b0;
      r_reject <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
      r_fault  <= 1'b0;
      r_moves  <= 5'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_wd     <= w_wd_nxt;
      // Outputs are decoded from the next state so they line up with the state register.
      r_start  <= (w_state_nxt == PLACE);
      r_load   <= (w_state_nxt == LOAD);
      r_decode <= (w_state_nxt == DECODE);
      r_alu    <= (w_state_nxt == ALU);
      r_ready  <= (w_state_nxt == READY);
      r_win    <= (w_state_nxt == WIN);
      r_lose   <= (w_state_nxt == LOSE);
      r_fault  <= (w_state_nxt == FAULT);
      r_reject <= w_reject;
      if (w_accept) begin
        r_data <= i_guess;
        if (r_moves != 5'd31) r_moves <= r_moves + 5'd1;
      end else if (w_new_ok) begin
        r_moves <= 5'd0;
      end
    end
  end

  assign o_start  = r_start;
  assign o_load   = r_load;
  assign o_decode = r_decode;
  assign o_alu    = r_alu;
  assign o_data   = r_data;
  assign o_ready  = r_ready;
  assign o_reject = r_reject;
  assign o_win    = r_win;
  assign o_lose   = r_lose;
  assign o_fault  = r_fault;
  assign o_moves  = r_moves;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl. It includes a small datapath responder that
// answers each command one cycle after seeing it.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        restart = 1'b1;
  logic        new_game = 1'b0;
  logic        guess_valid = 1'b0;
  logic [4:0]  guess = 5'd0;
  logic        place_done, decode_done, alu_done, gameover;
  logic [31:0] mines_w;
  logic [31:0] clr_w;
  logic        o_start, o_load, o_decode, o_alu, o_ready, o_reject, o_win, o_lose, o_fault;
  logic [4:0]  o_data, o_moves;

  logic        dec_en = 1'b1, alu_en = 1'b1, mark_en = 1'b1;
  logic        force_clr = 1'b0;
  logic [31:0] clr_val = 32'd0;

  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  assign mines_w = (32'd1 << 19) | (32'd1 << 21);

  game_ctrl dut (
    .i_clka(clk), .i_restart(restart), .i_new_game(new_game),
    .i_guess_valid(guess_valid), .i_guess(guess),
    .i_place_done(place_done), .i_decode_done(decode_done), .i_alu_done(alu_done),
    .i_gameover(gameover), .i_mines(mines_w[24:0]), .i_cleared(clr_w[24:0]),
    .o_start(o_start), .o_load(o_load), .o_decode(o_decode), .o_alu(o_alu),
    .o_data(o_data), .o_ready(o_ready), .o_reject(o_reject),
    .o_win(o_win), .o_lose(o_lose), .o_fault(o_fault), .o_moves(o_moves)
  );

  // Datapath responder.
  always @(posedge clk) begin
    if (restart) begin
      clr_w       <= 32'd0;
      place_done  <= 1'b0;
      decode_done <= 1'b0;
      alu_done    <= 1'b0;
      gameover    <= 1'b0;
    end else begin
      if (force_clr) clr_w <= clr_val;
      place_done <= o_start;
      if (o_load) begin
        decode_done <= 1'b0;
        alu_done    <= 1'b0;
      end else begin
        decode_done <= o_decode & dec_en;
        alu_done    <= o_alu & alu_en;
      end
      if (o_decode) gameover <= mines_w[o_data];
      if (o_alu && mark_en && !mines_w[o_data]) clr_w[o_data] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] all_out();
    return {o_start, o_load, o_decode, o_alu, o_data, o_ready, o_reject,
            o_win, o_lose, o_fault, o_moves};
  endfunction

  task automatic wait_ready(input string tag, input int limit);
    int n = 0;
    while (!o_ready && n < limit) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, o_ready}, 32'd1);
  endtask

  task automatic do_guess(input logic [4:0] g);
    guess = g;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    wait_ready("guess_return", 12);
  endtask

  initial begin
    // Reset.
    tick();
    tick();
    chk("reset_outputs", 32'(all_out()), 32'd0);
    restart = 1'b0;
    tick();
    chk("idle_outputs", 32'(all_out()), 32'd0);

    // New game: start should be high for 2 cycles, with READY in the 3rd cycle.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (o_start) cnt++;
      if (o_ready) begin
        chk("ready_latency", i, 3);
        break;
      end
      tick();
    end
    chk("start_width", cnt, 2);
    chk("ready_after_place", {31'd0, o_ready}, 32'd1);
    chk("moves_new", {27'd0, o_moves}, 32'd0);

    // new_game is ignored while in READY.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ng_ignored_ready", {30'd0, o_start, o_ready}, 32'b01);

    // Safe guess 3.
    guess = 5'd3;
    guess_valid = 1'b1;
    tick();                                  // t+1
    guess_valid = 1'b0;
    chk("t1_load", {28'd0, o_start, o_load, o_decode, o_alu}, 32'b0100);
    chk("t1_moves", {27'd0, o_moves}, 32'd1);
    tick();                                  // t+2
    chk("t2_decode", {28'd0, o_start, o_load, o_decode, o_alu}, 32'b0010);
    chk("t2_data", {27'd0, o_data}, 32'd3);
    tick();
    tick();                                  // t+4
    chk("t4_alu", {28'd0, o_start, o_load, o_decode, o_alu}, 32'b0001);
    tick();
    tick();                                  // t+6 CHECK
    chk("t6_check", {27'd0, o_start, o_load, o_decode, o_alu, o_ready}, 32'd0);
    tick();                                  // t+7
    chk("t7_ready", {29'd0, o_ready, o_win, o_lose}, 32'b100);
    chk("t7_data", {27'd0, o_data}, 32'd3);

    // Rejects: guesses 25 and 31 are out of range, and 3 is already cleared.
    for (int k = 0; k < 3; k++) begin
      guess = (k == 0) ? 5'd25 : (k == 1) ? 5'd31 : 5'd3;
      guess_valid = 1'b1;
      tick();
      guess_valid = 1'b0;
      chk("reject_pulse", {29'd0, o_reject, o_load, o_ready}, 32'b101);
      tick();
      chk("reject_drop", {30'd0, o_reject, o_load}, 32'd0);
    end
    chk("reject_moves", {27'd0, o_moves}, 32'd1);

    // Mine hit on guess 19.
    guess = 5'd19;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    repeat (6) tick();                       // t+7
    chk("lose_flag", {29'd0, o_lose, o_win, o_ready}, 32'b100);
    chk("lose_moves", {27'd0, o_moves}, 32'd2);
    guess = 5'd5;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    chk("lose_guess_ignored", {29'd0, o_load, o_reject, o_lose}, 32'b001);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("lose_newgame", {29'd0, o_start, o_lose, 1'b0}, 32'b100);
    chk("lose_moves_clr", {27'd0, o_moves}, 32'd0);
    wait_ready("ready_game2", 10);

    // Saturation: 32 accepted guesses of cell 0, none of which marks the board.
    mark_en = 1'b0;
    for (int k = 0; k < 32; k++) do_guess(5'd0);
    chk("moves_sat", {27'd0, o_moves}, 32'd31);
    mark_en = 1'b1;
    clr_val = 32'h01FF_FFFF & ~((32'd1 << 19) | (32'd1 << 21) | (32'd1 << 24));
    force_clr = 1'b1;
    tick();
    force_clr = 1'b0;
    guess = 5'd24;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    repeat (5) tick();                       // t+6 CHECK
    chk("win_not_yet", {30'd0, o_win, o_ready}, 32'd0);
    tick();                                  // t+7
    chk("win_flag", {29'd0, o_win, o_lose, o_ready}, 32'b100);
    chk("win_moves", {27'd0, o_moves}, 32'd31);

    // Watchdog: alu_done never arrives.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("win_newgame", {30'd0, o_start, o_win}, 32'b10);
    wait_ready("ready_game3", 10);
    alu_en = 1'b0;
    guess = 5'd19;
    guess_valid = 1'b1;
    tick();                                  // t+1
    guess_valid = 1'b0;
    repeat (17) tick();                      // t+18: last ALU cycle
    chk("wd_alu_last", {30'd0, o_alu, o_fault}, 32'b10);
    tick();                                  // t+19
    chk("wd_fault", {28'd0, o_alu, o_fault, o_ready, o_start}, 32'b0100);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("fault_sticky", {30'd0, o_fault, o_start}, 32'b10);

    // Restart in the middle of DECODE.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_fault_clr", 32'(all_out()), 32'd0);
    alu_en = 1'b1;
    dec_en = 1'b0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    wait_ready("ready_game4", 10);
    guess = 5'd2;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
    tick();
    chk("decode_hold", {31'd0, o_decode}, 32'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_mid_decode", 32'(all_out()), 32'd0);
    tick();
    chk("restart_idle", 32'(all_out()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
